draw_rect_text: RTL and testbench



---
 rtl/draw_rect_text_if.sv | 13 +
 rtl/draw_rect_text.sv | 178 +++++++++++++++++
 tb/tb_draw_rect_text.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/draw_rect_text_if.sv
// VGA timing + colour bundle passed between pipeline stages of the video chain.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_rect_text.sv
// Text-box overlay: maps each pixel to a character cell, addresses an external
// text/font ROM and overlays the returned glyph row, latency-matched to the ROM.
module draw_rect_text #(
  parameter int          X              = 0,
  parameter int          Y              = 0,
  parameter int          COLUMNS        = 16,
  parameter int          ROWS           = 16,
  parameter int          CWIDTH         = 8,
  parameter int          CHEIGHT        = 16,
  parameter int          SCALE          = 1,
  parameter int          FONT_LAT       = 1,
  parameter int          N_MSG          = 4,
  parameter logic [11:0] FG_RGB         = 12'hfff,
  parameter logic [11:0] BG_RGB         = 12'h000,
  parameter int          TRANSPARENT_BG = 0,
  parameter int          BLINK_LOG2     = 5,
  localparam int         MSG_W          = (N_MSG > 1) ? $clog2(N_MSG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              blink_en,
  input  logic [MSG_W-1:0]  msg_sel,
  input  logic [CWIDTH-1:0] char_pixel,
  output logic [7:0]        char_xy,
  output logic [3:0]        char_line,
  output logic [MSG_W-1:0]  msg_idx,
  vga_if.in                 in,
  vga_if.out                out
);
  localparam int CELL_W = CWIDTH * SCALE;
  localparam int CELL_H = CHEIGHT * SCALE;
  localparam int BOX_W  = COLUMNS * CELL_W;
  localparam int BOX_H  = ROWS * CELL_H;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
    logic        active;
    logic        en;
    logic [2:0]  bit_idx;
  } pix_t;

  pix_t                  pipe_r [FONT_LAT+1];
  pix_t                  stage_a_s;
  pix_t                  tail_s;
  logic [31:0]           hc_s;
  logic [31:0]           vc_s;
  logic [31:0]           dx_s;
  logic [31:0]           dy_s;
  logic                  active_s;
  logic [7:0]            cell_xy_s;
  logic [3:0]            cell_line_s;
  logic                  pixel_on_s;
  logic                  vsync_rise_s;
  logic                  vsync_prev_r;
  logic                  visible_r;
  logic [BLINK_LOG2-1:0] frame_cnt_r;
  logic [BLINK_LOG2-1:0] frame_next_s;

  // Box test (compare before subtracting so left/top of box never wraps in) and cell decode.
  always_comb begin
    hc_s     = {21'd0, in.hcount};
    vc_s     = {21'd0, in.vcount};
    active_s = (hc_s >= 32'(X)) && (hc_s < 32'(X + BOX_W)) &&
               (vc_s >= 32'(Y)) && (vc_s < 32'(Y + BOX_H));
    dx_s     = hc_s - 32'(X);
    dy_s     = vc_s - 32'(Y);

    stage_a_s        = '0;
    stage_a_s.hcount = in.hcount;
    stage_a_s.vcount = in.vcount;
    stage_a_s.hsync  = in.hsync;
    stage_a_s.vsync  = in.vsync;
    stage_a_s.hblnk  = in.hblnk;
    stage_a_s.vblnk  = in.vblnk;
    stage_a_s.rgb    = in.rgb;
    stage_a_s.active = active_s;
    stage_a_s.en     = enable;
    if (active_s) begin
      cell_xy_s         = {4'(dx_s / 32'(CELL_W)), 4'(dy_s / 32'(CELL_H))};
      cell_line_s       = 4'((dy_s / 32'(SCALE)) % 32'(CHEIGHT));
      stage_a_s.bit_idx = 3'((dx_s / 32'(SCALE)) % 32'(CWIDTH));
    end else begin
      cell_xy_s         = 8'd0;
      cell_line_s       = 4'd0;
      stage_a_s.bit_idx = 3'd0;
    end
  end

  // Stage A address register followed by FONT_LAT delay stages matching the ROM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= FONT_LAT; i++) begin
        pipe_r[i] <= '0;
      end
      char_xy   <= 8'd0;
      char_line <= 4'd0;
    end else begin
      pipe_r[0] <= stage_a_s;
      for (int i = 1; i <= FONT_LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
      char_xy   <= cell_xy_s;
      char_line <= cell_line_s;
    end
  end

  assign tail_s     = pipe_r[FONT_LAT];
  assign pixel_on_s = char_pixel[3'(CWIDTH - 1) - tail_s.bit_idx];

  // Stage B: glyph/background/pass-through select; blanking forces black.
  always_ff @(posedge clk) begin
    if (rst) begin
      out.hcount <= 11'd0;
      out.vcount <= 11'd0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= 12'h000;
    end else begin
      out.hcount <= tail_s.hcount;
      out.vcount <= tail_s.vcount;
      out.hsync  <= tail_s.hsync;
      out.vsync  <= tail_s.vsync;
      out.hblnk  <= tail_s.hblnk;
      out.vblnk  <= tail_s.vblnk;
      if (tail_s.hblnk || tail_s.vblnk) begin
        out.rgb <= 12'h000;
      end else if (tail_s.active && tail_s.en && visible_r) begin
        if (pixel_on_s) begin
          out.rgb <= FG_RGB;
        end else if (TRANSPARENT_BG != 0) begin
          out.rgb <= tail_s.rgb;
        end else begin
          out.rgb <= BG_RGB;
        end
      end else begin
        out.rgb <= tail_s.rgb;
      end
    end
  end

  assign vsync_rise_s = in.vsync && !vsync_prev_r;
  assign frame_next_s = frame_cnt_r + BLINK_LOG2'(1);

  // Frame-boundary state: blink counter, visibility and message latch change only on vsync rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_prev_r <= 1'b0;
      frame_cnt_r  <= '0;
      visible_r    <= 1'b0;
      msg_idx      <= '0;
    end else begin
      vsync_prev_r <= in.vsync;
      if (vsync_rise_s) begin
        frame_cnt_r <= frame_next_s;
        visible_r   <= !blink_en || !frame_next_s[BLINK_LOG2-1];
        if (32'(msg_sel) >= 32'(N_MSG)) begin
          msg_idx <= MSG_W'(N_MSG - 1);
        end else begin
          msg_idx <= msg_sel;
        end
      end else begin
        frame_cnt_r <= frame_cnt_r;
        visible_r   <= visible_r;
        msg_idx     <= msg_idx;
      end
    end
  end

endmodule

// File: tb/tb_draw_rect_text.sv
// Directed bench for draw_rect_text: four parameterisations share one input stream.
module tb_draw_rect_text;
  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       blink_en;
  logic [1:0] msg_sel;
  logic [7:0] char_pixel;
  logic [7:0] xy0, xy1, xy2, xy3;
  logic [3:0] ln0, ln1, ln2, ln3;
  logic [1:0] mi0, mi1, mi2, mi3;
  int         n_cmp;
  int         n_err;

  always #5 clk = ~clk;

  vga_if vin();
  vga_if vo0();
  vga_if vo1();
  vga_if vo2();
  vga_if vo3();

  draw_rect_text u0 (
    .clk(clk), .rst(rst), .enable(enable), .blink_en(blink_en), .msg_sel(msg_sel),
    .char_pixel(char_pixel), .char_xy(xy0), .char_line(ln0), .msg_idx(mi0),
    .in(vin), .out(vo0));

  draw_rect_text #(.X(100), .Y(50), .SCALE(2)) u1 (
    .clk(clk), .rst(rst), .enable(enable), .blink_en(blink_en), .msg_sel(msg_sel),
    .char_pixel(char_pixel), .char_xy(xy1), .char_line(ln1), .msg_idx(mi1),
    .in(vin), .out(vo1));

  draw_rect_text #(.TRANSPARENT_BG(1)) u2 (
    .clk(clk), .rst(rst), .enable(enable), .blink_en(blink_en), .msg_sel(msg_sel),
    .char_pixel(char_pixel), .char_xy(xy2), .char_line(ln2), .msg_idx(mi2),
    .in(vin), .out(vo2));

  draw_rect_text #(.BLINK_LOG2(2), .N_MSG(3)) u3 (
    .clk(clk), .rst(rst), .enable(enable), .blink_en(blink_en), .msg_sel(msg_sel),
    .char_pixel(char_pixel), .char_xy(xy3), .char_line(ln3), .msg_idx(mi3),
    .in(vin), .out(vo3));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic set_px(input int h, input int v, input logic [11:0] rgb);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hsync  = 1'b0;
    vin.vsync  = 1'b0;
    vin.hblnk  = 1'b0;
    vin.vblnk  = 1'b0;
    vin.rgb    = rgb;
  endtask

  task automatic vsync_edge();
    vin.vsync = 1'b1;
    tick();
    vin.vsync = 1'b0;
    tick();
  endtask

  logic [7:0] blink_pat;

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    enable     = 1'b1;
    blink_en   = 1'b0;
    msg_sel    = 2'd0;
    char_pixel = 8'b1000_0001;
    set_px(5, 7, 12'h123);
    tickn(3);
    check_val("rst_rgb", vo0.rgb, 12'h000);
    check_val("rst_vcount", vo0.vcount, 11'd0);
    check_val("rst_xy", xy0, 8'h00);
    check_val("rst_msg", mi0, 2'd0);
    rst = 1'b0;
    vsync_edge();

    // Glyph row 1000_0001 across cell 0, three-cycle latency
    for (int i = 0; i < 10; i++) begin
      if (i < 8) set_px(i, 0, 12'h123);
      else set_px(200, 300, 12'h456);
      tick();
      if (i == 0) begin
        check_val("t1_xy", xy0, 8'h00);
        check_val("t1_line", ln0, 4'd0);
      end
      if (i >= 2) begin
        check_val("t1_lat_hcount", vo0.hcount, 11'(i - 2));
        check_val("t1_rgb", vo0.rgb, ((i - 2) == 0 || (i - 2) == 7) ? 12'hfff : 12'h000);
      end
    end

    // Offset, scaled box: cell (3,2), line 3, bit 2
    char_pixel = 8'b0010_0000;
    set_px(153, 121, 12'h123);
    tickn(3);
    check_val("t2_xy", xy1, 8'h32);
    check_val("t2_line", ln1, 4'd3);
    check_val("t2_rgb_bit2", vo1.rgb, 12'hfff);
    check_val("t2_outside_default", vo0.rgb, 12'h123);
    set_px(99, 50, 12'h123);
    tickn(3);
    check_val("t2_left_rgb", vo1.rgb, 12'h123);
    check_val("t2_left_xy", xy1, 8'h00);
    set_px(100, 49, 12'h123);
    tickn(3);
    check_val("t2_top_rgb", vo1.rgb, 12'h123);
    check_val("t2_top_line", ln1, 4'd0);
    set_px(355, 50, 12'h123);
    tickn(3);
    check_val("t2_right_xy", xy1, 8'hf0);
    check_val("t2_right_rgb", vo1.rgb, 12'h000);
    set_px(356, 50, 12'h123);
    tickn(3);
    check_val("t2_past_rgb", vo1.rgb, 12'h123);
    check_val("t2_past_xy", xy1, 8'h00);

    // Transparent background, enable gating, blanking override
    char_pixel = 8'h00;
    set_px(10, 10, 12'h0a0);
    tickn(3);
    check_val("t3_transp_bg", vo2.rgb, 12'h0a0);
    check_val("t3_opaque_bg", vo0.rgb, 12'h000);
    char_pixel = 8'hff;
    tickn(3);
    check_val("t3_transp_fg", vo2.rgb, 12'hfff);
    enable = 1'b0;
    tickn(3);
    check_val("t3_disabled", vo0.rgb, 12'h0a0);
    enable = 1'b1;
    vin.hblnk = 1'b1;
    tickn(3);
    check_val("t3_hblnk_rgb", vo0.rgb, 12'h000);
    check_val("t3_hblnk_flag", vo0.hblnk, 1'b1);
    check_val("t3_hblnk_transp", vo2.rgb, 12'h000);
    vin.hblnk = 1'b0;
    vin.vblnk = 1'b1;
    tickn(3);
    check_val("t3_vblnk_rgb", vo0.rgb, 12'h000);
    vin.vblnk = 1'b0;

    // Message latch only at vsync rise, with clamping
    msg_sel = 2'd2;
    tickn(4);
    check_val("t4_msg_hold", mi0, 2'd0);
    vin.vsync = 1'b1;
    tick();
    check_val("t4_msg_latch", mi0, 2'd2);
    vin.vsync = 1'b0;
    tick();
    msg_sel = 2'd3;
    vsync_edge();
    check_val("t4_msg_3", mi0, 2'd3);
    check_val("t4_msg_clamp", mi3, 2'd2);

    // Blink with 2-bit frame counter
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("t5_rst_msg", mi0, 2'd0);
    blink_en   = 1'b1;
    char_pixel = 8'hff;
    blink_pat  = 8'b1001_1001;
    for (int k = 0; k < 8; k++) begin
      set_px(10, 10, 12'h123);
      vsync_edge();
      tickn(3);
      check_val("t5_blink", vo3.rgb, blink_pat[7-k] ? 12'hfff : 12'h123);
    end
    blink_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vsync_edge();
      tickn(3);
      check_val("t5_noblink", vo3.rgb, 12'hfff);
    end

    // Reset mid-line, then refill
    for (int i = 0; i < 4; i++) begin
      set_px(30 + i, 20, 12'h0f0);
      vin.hsync = 1'b1;
      tick();
    end
    rst = 1'b1;
    set_px(34, 20, 12'h0f0);
    vin.hsync = 1'b1;
    tick();
    rst = 1'b0;
    check_val("t6_rst_hcount", vo0.hcount, 11'd0);
    check_val("t6_rst_vcount", vo0.vcount, 11'd0);
    check_val("t6_rst_hsync", vo0.hsync, 1'b0);
    check_val("t6_rst_rgb", vo0.rgb, 12'h000);
    check_val("t6_rst_xy", xy0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      set_px(40 + i, 20, 12'h0f0);
      vin.hsync = 1'b1;
      tick();
      if (i < 2) begin
        check_val("t6_refill_zero", vo0.hcount, 11'd0);
      end else begin
        check_val("t6_track_hcount", vo0.hcount, 11'(40 + i - 2));
        check_val("t6_track_rgb", vo0.rgb, 12'h0f0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
